sw_seq_gen: RTL and testbench

Self-test switch sequencer that drives the `sw[2:0]` command port of the LED state machine from hardware rather than from a bench. On `start` it plays a fixed seven-step script of switch codes, holding each code and then inserting an all-zero gap. With the checker compiled in, it samples the state machine's `led[2:0]` at the end of every gap and flags any mismatch against an expected table. It sits between board-level start/abort controls and the `fsm` instance.

---
 rtl/sw_seq_pkg.sv | 21 ++
 rtl/sw_seq_timer.sv | 27 ++
 rtl/sw_seq_gen.sv | 130 +++++++++++++
 tb/tb_sw_seq_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_seq_pkg.sv
// Shared constants for the self-test switch sequencer:
// state encoding, script length, switch codes and expected led values.
package sw_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int SCRIPT_LEN = 7;

  localparam logic [2:0] SW_CODE [0:6] = '{
    3'b001, 3'b010, 3'b011, 3'b100,
    3'b101, 3'b110, 3'b111
  };

  localparam logic [2:0] LED_EXP [0:6] = '{
    3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd0, 3'd3
  };

endpackage

// File: rtl/sw_seq_timer.sv
// Loadable down-counter timing the hold and gap phases.
// Ports: clk, rst_n (sync), load, len -> expire (count == 1).
module sw_seq_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= len;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/sw_seq_gen.sv
// Self-test switch sequencer: plays a 7-step sw script with gaps.
// Ports: clk, reset (sync, active-low), start, abort, led in;
// sw, step, busy, done, err, err_step out.
// Macro SW_SEQ_CHECK_EN enables the led checker (err, err_step).
module sw_seq_gen
  import sw_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] led,
  output logic [2:0] sw,
  output logic [2:0] step,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] err_step
);

  localparam int MAXC =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [2:0] LAST = 3'(SCRIPT_LEN - 1);

  logic [1:0]    state;
  logic          expire;
  logic          to_gap;
  logic          adv;
  logic          fin;
  logic          launch;
  logic          retire;
  logic          load;
  logic [TW-1:0] len;

  assign to_gap = !abort && state == S_HOLD && expire;
  assign adv    = !abort && state == S_GAP && expire
                  && step != LAST;
  assign fin    = !abort && state == S_GAP && expire
                  && step == LAST;
  // A start seen on the completing edge chains straight
  // into the next script.
  assign launch = !abort && start
                  && (state == S_IDLE || fin);
  assign retire = fin && !start;

  assign load = launch || to_gap || adv;
  assign len  = to_gap ? TW'(GAP_CYCLES)
                       : TW'(HOLD_CYCLES);

  sw_seq_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .load   (load),
    .len    (len),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      step  <= '0;
      sw    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= fin;
      unique case (1'b1)
        abort: begin
          state <= S_IDLE;
          step  <= '0;
          sw    <= '0;
          busy  <= 1'b0;
        end
        launch: begin
          state <= S_HOLD;
          step  <= '0;
          sw    <= SW_CODE[0];
          busy  <= 1'b1;
        end
        to_gap: begin
          state <= S_GAP;
          sw    <= '0;
        end
        adv: begin
          state <= S_HOLD;
          step  <= step + 3'd1;
          sw    <= SW_CODE[step + 3'd1];
        end
        retire: begin
          state <= S_IDLE;
          step  <= '0;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SW_SEQ_CHECK_EN
  logic chk;

  // Last cycle of every gap.
  assign chk = adv || fin;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err      <= 1'b0;
      err_step <= '0;
    end else if (launch) begin
      err      <= 1'b0;
      err_step <= '0;
    end else if (chk && led != LED_EXP[step]) begin
      err <= 1'b1;
      if (!err)
        err_step <= step;
    end
  end
`else
  logic unused_led;

  assign unused_led = ^led;
  assign err        = 1'b0;
  assign err_step   = '0;
`endif

endmodule

// File: tb/tb_sw_seq_gen.sv
// Directed bench for sw_seq_gen: HOLD=GAP=1 and HOLD=3/GAP=2
// instances, led supplied by a small state-machine model.
module tb_sw_seq_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       abort = 1'b0;
  logic       force_a = 1'b0;
  logic [2:0] led_a, led_b, lm_a, lm_b;
  logic [2:0] sw_a, sw_b, step_a, step_b, es_a, es_b;
  logic       busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [2:0] exp_sw;
  int         checks = 0;
  int         errors = 0;

`ifdef SW_SEQ_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  sw_seq_gen #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .abort(abort), .led(led_a), .sw(sw_a),
    .step(step_a), .busy(busy_a), .done(done_a),
    .err(err_a), .err_step(es_a)
  );

  sw_seq_gen #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .abort(abort), .led(led_b), .sw(sw_b),
    .step(step_b), .busy(busy_b), .done(done_b),
    .err(err_b), .err_step(es_b)
  );

  function automatic logic [2:0] fsm_led(input logic [2:0] s);
    case (s)
      3'b001:  return 3'd1;
      3'b010:  return 3'd2;
      3'b011:  return 3'd3;
      3'b100:  return 3'd4;
      3'b101:  return 3'd5;
      3'b110:  return 3'd0;
      3'b111:  return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      lm_a <= '0;
      lm_b <= '0;
    end else begin
      if (sw_a != 3'd0) lm_a <= fsm_led(sw_a);
      if (sw_b != 3'd0) lm_b <= fsm_led(sw_b);
    end
  end

  assign led_a = force_a ? 3'd0 : lm_a;
  assign led_b = lm_b;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (sw_a !== 3'd0 || step_a !== 3'd0 || busy_a !== 1'b0
        || done_a !== 1'b0 || err_a !== 1'b0 || es_a !== 3'd0) begin
      errors++;
      $display("FAIL reset_a: sw=%b step=%0d busy=%b done=%b err=%b es=%0d, want all 0",
               sw_a, step_a, busy_a, done_a, err_a, es_a);
    end
    checks++;
    if (sw_b !== 3'd0 || step_b !== 3'd0 || busy_b !== 1'b0
        || done_b !== 1'b0 || err_b !== 1'b0 || es_b !== 3'd0) begin
      errors++;
      $display("FAIL reset_b: sw=%b step=%0d busy=%b done=%b err=%b es=%0d, want all 0",
               sw_b, step_b, busy_b, done_b, err_b, es_b);
    end
  endtask

  task automatic test_hold1;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int e = 0; e < 14; e++) begin
      if (e > 0) tick;
      exp_sw = (e % 2 == 0) ? 3'(e / 2 + 1) : 3'd0;
      checks++;
      if (sw_a !== exp_sw || step_a !== 3'(e / 2)
          || busy_a !== 1'b1 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL hold1 edge %0d: sw=%b step=%0d busy=%b done=%b, want sw=%b step=%0d busy=1 done=0",
                 e, sw_a, step_a, busy_a, done_a, exp_sw, e / 2);
      end
    end
    tick;
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0
        || sw_a !== 3'd0 || step_a !== 3'd0) begin
      errors++;
      $display("FAIL hold1_done: done=%b busy=%b sw=%b step=%0d, want 1 0 000 0",
               done_a, busy_a, sw_a, step_a);
    end
    checks++;
    if (err_a !== 1'b0) begin
      errors++;
      $display("FAIL hold1_err: err=%b, want 0", err_a);
    end
    tick;
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL hold1_pulse: done=%b, want 0", done_a);
    end
  endtask

  task automatic test_hold3;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int e = 0; e < 35; e++) begin
      if (e > 0) tick;
      exp_sw = (e % 5 < 3) ? 3'(e / 5 + 1) : 3'd0;
      checks++;
      if (sw_b !== exp_sw || step_b !== 3'(e / 5)
          || busy_b !== 1'b1 || done_b !== 1'b0) begin
        errors++;
        $display("FAIL hold3 edge %0d: sw=%b step=%0d busy=%b done=%b, want sw=%b step=%0d busy=1 done=0",
                 e, sw_b, step_b, busy_b, done_b, exp_sw, e / 5);
      end
    end
    tick;
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL hold3_done: done=%b busy=%b err=%b, want 1 0 0",
               done_b, busy_b, err_b);
    end
  endtask

  task automatic test_abort;
    int seen;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (6) tick;
    checks++;
    if (sw_a !== 3'b100 || step_a !== 3'd3) begin
      errors++;
      $display("FAIL abort_pre: sw=%b step=%0d, want 100 3",
               sw_a, step_a);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (sw_a !== 3'd0 || busy_a !== 1'b0
        || step_a !== 3'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL abort: sw=%b busy=%b step=%0d done=%b, want 000 0 0 0",
               sw_a, busy_a, step_a, done_a);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done_a === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_nodone: done pulses=%0d, want 0", seen);
    end
    start_a = 1'b1;
    abort = 1'b1;
    tick;
    start_a = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || sw_a !== 3'd0) begin
      errors++;
      $display("FAIL start_abort: busy=%b sw=%b, want 0 000",
               busy_a, sw_a);
    end
  endtask

  task automatic test_reset_mid;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (8) tick;
    checks++;
    if (step_a !== 3'd4 || sw_a !== 3'b101) begin
      errors++;
      $display("FAIL rmid_pre: step=%0d sw=%b, want 4 101",
               step_a, sw_a);
    end
    reset = 1'b0;
    tick;
    reset = 1'b1;
    checks++;
    if (sw_a !== 3'd0 || step_a !== 3'd0 || busy_a !== 1'b0
        || done_a !== 1'b0 || err_a !== 1'b0 || es_a !== 3'd0) begin
      errors++;
      $display("FAIL rmid: sw=%b step=%0d busy=%b done=%b err=%b es=%0d, want all 0",
               sw_a, step_a, busy_a, done_a, err_a, es_a);
    end
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    checks++;
    if (sw_a !== 3'b001 || step_a !== 3'd0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL rmid_restart: sw=%b step=%0d busy=%b, want 001 0 1",
               sw_a, step_a, busy_a);
    end
    repeat (14) tick;
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL rmid_done: done=%b, want 1", done_a);
    end
  endtask

  task automatic test_check;
    force_a = 1'b1;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (2) tick;
    checks++;
    if (err_a !== CHK || es_a !== 3'd0) begin
      errors++;
      $display("FAIL chk_first: err=%b es=%0d, want %b 0",
               err_a, es_a, CHK);
    end
    repeat (12) tick;
    checks++;
    if (done_a !== 1'b1 || err_a !== CHK || es_a !== 3'd0) begin
      errors++;
      $display("FAIL chk_end: done=%b err=%b es=%0d, want 1 %b 0",
               done_a, err_a, es_a, CHK);
    end
    force_a = 1'b0;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    checks++;
    if (err_a !== 1'b0 || es_a !== 3'd0) begin
      errors++;
      $display("FAIL chk_clear: err=%b es=%0d, want 0 0",
               err_a, es_a);
    end
    repeat (14) tick;
    checks++;
    if (done_a !== 1'b1 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL chk_clean: done=%b err=%b, want 1 0",
               done_a, err_a);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_done;
    start_a = 1'b1;
    tick;
    for (int e = 1; e <= 42; e++) begin
      tick;
      exp_done = (e % 14 == 0);
      checks++;
      if (done_a !== exp_done || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL b2b edge %0d: done=%b busy=%b, want %b 1",
                 e, done_a, busy_a, exp_done);
      end
      if (e == 14) begin
        checks++;
        if (sw_a !== 3'b001 || step_a !== 3'd0) begin
          errors++;
          $display("FAIL b2b_restart: sw=%b step=%0d, want 001 0",
                   sw_a, step_a);
        end
      end
    end
    start_a = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) tick;
    test_reset;
    reset = 1'b1;
    tick;
    test_hold1;
    test_hold3;
    test_abort;
    test_reset_mid;
    tick;
    test_check;
    tick;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
